// File: rtl/mcp4922_pkg.sv
// Shared types for the MCP4922 DAC driver: FSM encoding, frame bit positions
// and the frame builder.
package mcp4922_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_HOLD,
        S_GAP,
        S_LDAC
    } state_t;

    localparam int FRM_CH     = 15;
    localparam int FRM_BUF    = 14;
    localparam int FRM_GA_N   = 13;
    localparam int FRM_SHDN_N = 12;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    // Upper nibble of the stream sample is dropped; the config bits take its place.
    function automatic logic [15:0] build_frame(logic ch, logic buf_en, logic ga_n,
                                                logic [15:0] sample);
        logic [15:0] f;
        f             = {4'b0000, sample[11:0]};
        f[FRM_CH]     = ch;
        f[FRM_BUF]    = buf_en;
        f[FRM_GA_N]   = ga_n;
        f[FRM_SHDN_N] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/axis_mcp4922_v1_0_if.sv
// AXI-Stream sample channel carrying one 16-bit DAC sample per beat.
interface mcp4922_axis_if;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_mcp4922_v1_0_hold.sv
// One-entry AXI-Stream sink: captures a sample and flags it pending until the
// serialiser takes it.
module axis_hold_reg
    import mcp4922_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mcp4922_axis_if.slave s_axis,
    input  logic          clear,
    output logic [15:0]   data,
    output logic          pending
);

    assign s_axis.tready = !pending && !reset;

    // clear only arrives while pending is set, so it never races a handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            data    <= '0;
        end else if (s_axis.tvalid && s_axis.tready) begin
            pending <= 1'b1;
            data    <= s_axis.tdata;
        end else if (clear) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_mcp4922_v1_0.sv
// MCP4922 dual-channel SPI DAC driver: two stream inputs, round-robin frame
// serialiser (SPI mode 0) and optional LDAC pulse once both channels are written.
module axis_mcp4922_v1_0
    import mcp4922_pkg::*;
#(
    parameter int prescaler_sclk       = 10,
    parameter int prescaler_sclk_width = 4,
    parameter bit buffered             = 1'b0,
    parameter bit gain_1x              = 1'b1,
    parameter bit sync_update          = 1'b1
) (
    input  logic          aclk,
    input  logic          reset,
    mcp4922_axis_if.slave s_axis_cha,
    mcp4922_axis_if.slave s_axis_chb,
    output logic          spi_mosi,
    output logic          spi_sclk,
    output logic          spi_ss,
    output logic          spi_ldac_n
);

    localparam logic [prescaler_sclk_width-1:0] PRESC_MAX =
        prescaler_sclk_width'(prescaler_sclk);

    logic [1:0]  pend, clr;
    logic [15:0] data_a, data_b;

    state_t                          state, state_nxt;
    logic [prescaler_sclk_width-1:0] presc, presc_nxt;
    logic                            tick;
    logic [15:0]                     shift, shift_nxt;
    logic [3:0]                      bit_cnt, bit_cnt_nxt;
    logic                            sclk_q, sclk_nxt, ss_q, ss_nxt, ldac_q, ldac_nxt;
    logic                            last_ch, last_nxt, cur_ch, cur_nxt, sel;
    logic [1:0]                      written, wr_nxt;

    axis_hold_reg u_hold_a (
        .clk(aclk), .reset(reset), .s_axis(s_axis_cha),
        .clear(clr[0]), .data(data_a), .pending(pend[0])
    );

    axis_hold_reg u_hold_b (
        .clk(aclk), .reset(reset), .s_axis(s_axis_chb),
        .clear(clr[1]), .data(data_b), .pending(pend[1])
    );

    assign tick       = (state != S_IDLE) && (presc == PRESC_MAX);
    assign spi_mosi   = shift[15];
    assign spi_sclk   = sclk_q;
    assign spi_ss     = ss_q;
    assign spi_ldac_n = sync_update ? ldac_q : 1'b0;

    always_ff @(posedge aclk) begin
        if (reset) begin
            state   <= S_IDLE;
            presc   <= '0;
            shift   <= '0;
            bit_cnt <= '0;
            sclk_q  <= 1'b0;
            ss_q    <= 1'b1;
            ldac_q  <= 1'b1;
            last_ch <= CH_B;
            cur_ch  <= CH_A;
            written <= '0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            shift   <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
            sclk_q  <= sclk_nxt;
            ss_q    <= ss_nxt;
            ldac_q  <= ldac_nxt;
            last_ch <= last_nxt;
            cur_ch  <= cur_nxt;
            written <= wr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        presc_nxt   = (state == S_IDLE || tick) ? '0 : presc + 1'b1;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        sclk_nxt    = sclk_q;
        ss_nxt      = ss_q;
        ldac_nxt    = ldac_q;
        last_nxt    = last_ch;
        cur_nxt     = cur_ch;
        wr_nxt      = written;
        clr         = '0;
        sel         = CH_A;
        case (state)
            S_IDLE: if (|pend) begin
                // both pending: serve the one not served last; else the lone one
                sel         = (pend == 2'b11) ? !last_ch : pend[1];
                clr[sel]    = 1'b1;
                shift_nxt   = build_frame(sel, buffered, gain_1x, sel ? data_b : data_a);
                cur_nxt     = sel;
                last_nxt    = sel;
                ss_nxt      = 1'b0;
                bit_cnt_nxt = 4'd15;
                state_nxt   = S_LOW;
            end
            S_LOW: if (tick) begin
                sclk_nxt  = 1'b1;
                state_nxt = S_HIGH;
            end
            S_HIGH: if (tick) begin
                sclk_nxt = 1'b0;
                if (bit_cnt == 4'd0) begin
                    state_nxt = S_HOLD;
                end else begin
                    shift_nxt   = {shift[14:0], 1'b0};
                    bit_cnt_nxt = bit_cnt - 1'b1;
                    state_nxt   = S_LOW;
                end
            end
            S_HOLD: if (tick) begin
                ss_nxt          = 1'b1;
                wr_nxt[cur_ch]  = 1'b1;
                state_nxt       = S_GAP;
            end
            S_GAP: if (tick) begin
                if (sync_update && (&written)) begin
                    ldac_nxt  = 1'b0;
                    wr_nxt    = '0;
                    state_nxt = S_LDAC;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_LDAC: if (tick) begin
                ldac_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axis_mcp4922_v1_0.sv
// Directed bench for axis_mcp4922_v1_0: frame capture at rising SCLK, CS/LDAC
// timing, round-robin, mid-frame reset and an unsynchronised/2x-gain variant.
module tb_axis_mcp4922_v1_0;

    localparam int P1 = 11;
    localparam int P2 = 2;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    logic rst1, rst2;
    logic mosi1, sclk1, ss1, ldac1;
    logic mosi2, sclk2, ss2, ldac2;

    mcp4922_axis_if ia1 ();
    mcp4922_axis_if ib1 ();
    mcp4922_axis_if ia2 ();
    mcp4922_axis_if ib2 ();

    axis_mcp4922_v1_0 #(
        .prescaler_sclk(10), .prescaler_sclk_width(4),
        .buffered(1'b0), .gain_1x(1'b1), .sync_update(1'b1)
    ) dut1 (
        .aclk(aclk), .reset(rst1), .s_axis_cha(ia1), .s_axis_chb(ib1),
        .spi_mosi(mosi1), .spi_sclk(sclk1), .spi_ss(ss1), .spi_ldac_n(ldac1)
    );

    axis_mcp4922_v1_0 #(
        .prescaler_sclk(1), .prescaler_sclk_width(4),
        .buffered(1'b1), .gain_1x(1'b0), .sync_update(1'b0)
    ) dut2 (
        .aclk(aclk), .reset(rst2), .s_axis_cha(ia2), .s_axis_chb(ib2),
        .spi_mosi(mosi2), .spi_sclk(sclk2), .spi_ss(ss2), .spi_ldac_n(ldac2)
    );

    int n_chk = 0, n_pass = 0;
    int ldac2_hi = 0;
    always @(negedge aclk) if (ldac2 !== 1'b0) ldac2_hi++;

    typedef struct {
        int          ch;
        logic [15:0] data;
        logic [15:0] frame;
        int          ldac_lows;
    } vec_t;
    vec_t vecs[4];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic ss_of(int d);   return (d == 0) ? ss1 : ss2;     endfunction
    function automatic logic sclk_of(int d); return (d == 0) ? sclk1 : sclk2; endfunction
    function automatic logic mosi_of(int d); return (d == 0) ? mosi1 : mosi2; endfunction
    function automatic logic ldac_of(int d); return (d == 0) ? ldac1 : ldac2; endfunction
    function automatic logic rdy_of(int d, int ch);
        if (d == 0) return (ch == 0) ? ia1.tready : ib1.tready;
        return (ch == 0) ? ia2.tready : ib2.tready;
    endfunction

    task automatic set_src(int d, int ch, logic [15:0] data, logic v);
        if (d == 0 && ch == 0) begin ia1.tdata = data; ia1.tvalid = v; end
        else if (d == 0)       begin ib1.tdata = data; ib1.tvalid = v; end
        else if (ch == 0)      begin ia2.tdata = data; ia2.tvalid = v; end
        else                   begin ib2.tdata = data; ib2.tvalid = v; end
    endtask

    // returns at the negedge right after the accepting posedge
    task automatic send(int d, int ch, logic [15:0] data);
        bit ok;
        ok = 1'b0;
        @(negedge aclk);
        set_src(d, ch, data, 1'b1);
        for (int i = 0; i < 4000 && !ok; i++) begin
            if (rdy_of(d, ch)) ok = 1'b1;
            @(posedge aclk);
            @(negedge aclk);
        end
        set_src(d, ch, 16'h0000, 1'b0);
        if (!ok) check("send_tready", rdy_of(d, ch), 1);
    endtask

    task automatic capture(int d, int ch, int p, output logic [15:0] frame,
                           output int cs_len, output int fall, output int nbits,
                           output logic rdy_fall);
        logic prev;
        frame = '0; cs_len = 0; nbits = 0; fall = -1; prev = 1'b0; rdy_fall = 1'b0;
        for (int i = 0; i < 40 * p && ss_of(d); i++) @(negedge aclk);
        if (ss_of(d)) begin
            check("cs_fall_timeout", ss_of(d), 0);
            return;
        end
        fall = cyc;
        rdy_fall = rdy_of(d, ch);
        for (int i = 0; i < 40 * p && !ss_of(d); i++) begin
            cs_len++;
            if (sclk_of(d) && !prev) begin
                frame = {frame[14:0], mosi_of(d)};
                nbits++;
            end
            prev = sclk_of(d);
            @(negedge aclk);
        end
    endtask

    task automatic count_ldac(int d, int n, output int lows);
        lows = 0;
        for (int i = 0; i < n; i++) begin
            if (ldac_of(d) == 1'b0) lows++;
            @(negedge aclk);
        end
    endtask

    initial begin
        logic [15:0] frame;
        int cs_len, fall, fall1, nbits, lows, t0, rises, sslow;
        logic rdy_f, prev;

        vecs[0] = '{0, 16'h0ABC, 16'h3ABC, 0};
        vecs[1] = '{1, 16'h0123, 16'hB123, P1};
        vecs[2] = '{0, 16'hFABC, 16'h3ABC, 0};
        vecs[3] = '{1, 16'h7FFF, 16'hBFFF, P1};

        rst1 = 1'b1; rst2 = 1'b1;
        set_src(0, 0, 16'h0, 1'b0); set_src(0, 1, 16'h0, 1'b0);
        set_src(1, 0, 16'h0, 1'b0); set_src(1, 1, 16'h0, 1'b0);
        repeat (3) @(negedge aclk);
        check("rst_ss", ss1, 1);
        check("rst_sclk", sclk1, 0);
        check("rst_mosi", mosi1, 0);
        check("rst_ldac", ldac1, 1);
        check("rst_rdy_a", ia1.tready, 0);
        check("rst_rdy_b", ib1.tready, 0);
        rst1 = 1'b0;
        @(negedge aclk);
        check("post_rst_rdy_a", ia1.tready, 1);
        check("post_rst_rdy_b", ib1.tready, 1);

        for (int i = 0; i < 4; i++) begin
            send(0, vecs[i].ch, vecs[i].data);
            t0 = cyc;
            check($sformatf("v%0d_ss_pre", i), ss1, 1);
            check($sformatf("v%0d_rdy_busy", i), rdy_of(0, vecs[i].ch), 0);
            capture(0, vecs[i].ch, P1, frame, cs_len, fall, nbits, rdy_f);
            check($sformatf("v%0d_latency", i), fall - t0, 1);
            check($sformatf("v%0d_frame", i), frame, vecs[i].frame);
            check($sformatf("v%0d_bits", i), nbits, 16);
            check($sformatf("v%0d_cs_len", i), cs_len, 33 * P1);
            check($sformatf("v%0d_rdy_after_load", i), rdy_f, 1);
            count_ldac(0, 3 * P1, lows);
            check($sformatf("v%0d_ldac_lows", i), lows, vecs[i].ldac_lows);
        end

        // both channels valid in the same cycle straight after reset
        rst1 = 1'b1;
        repeat (2) @(negedge aclk);
        rst1 = 1'b0;
        @(negedge aclk);
        set_src(0, 0, 16'h0111, 1'b1);
        set_src(0, 1, 16'h0222, 1'b1);
        check("b2b_rdy_a", ia1.tready, 1);
        check("b2b_rdy_b", ib1.tready, 1);
        @(posedge aclk);
        @(negedge aclk);
        set_src(0, 0, 16'h0, 1'b0);
        set_src(0, 1, 16'h0, 1'b0);
        t0 = cyc;
        capture(0, 0, P1, frame, cs_len, fall1, nbits, rdy_f);
        check("b2b_lat", fall1 - t0, 1);
        check("b2b_frame_a", frame, 16'h3111);
        capture(0, 1, P1, frame, cs_len, fall, nbits, rdy_f);
        check("b2b_frame_b", frame, 16'hB222);
        check("b2b_period", fall - fall1, 1 + 34 * P1);
        count_ldac(0, 3 * P1, lows);
        check("b2b_ldac_lows", lows, P1);

        // reset asserted while bit 8 is on the wire
        send(0, 0, 16'h0555);
        rises = 0; prev = 1'b0;
        for (int i = 0; i < 40 * P1 && rises < 8; i++) begin
            @(negedge aclk);
            if (sclk1 && !prev) rises++;
            prev = sclk1;
        end
        check("mid_rises", rises, 8);
        rst1 = 1'b1;
        @(negedge aclk);
        check("mid_ss", ss1, 1);
        check("mid_sclk", sclk1, 0);
        check("mid_rdy_in_rst", ia1.tready, 0);
        rst1 = 1'b0;
        @(negedge aclk);
        check("mid_pend_clr", ia1.tready, 1);
        lows = 0; sslow = 0;
        for (int i = 0; i < 40 * P1; i++) begin
            if (!ldac1) lows++;
            if (!ss1) sslow++;
            @(negedge aclk);
        end
        check("mid_no_ldac", lows, 0);
        check("mid_no_frame", sslow, 0);

        // unsynchronised, buffered, 2x gain variant
        rst2 = 1'b0;
        @(negedge aclk);
        send(1, 0, 16'h0FFF);
        capture(1, 0, P2, frame, cs_len, fall, nbits, rdy_f);
        check("d2_frame_a", frame, 16'h5FFF);
        check("d2_cs_len", cs_len, 33 * P2);
        send(1, 1, 16'h0001);
        capture(1, 1, P2, frame, cs_len, fall, nbits, rdy_f);
        check("d2_frame_b", frame, 16'hD001);
        repeat (4 * P2) @(negedge aclk);
        check("d2_ldac_tied_low", ldac2_hi, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axis_mcp4922_v1_0.md
# axis_mcp4922_v1_0

Driver for the Microchip MCP4922 dual 12-bit SPI DAC, the transmit-side counterpart of the MCP3204 ADC driver. It provides two AXI-Stream slave inputs, one per DAC channel. Each input has a one-entry holding register. The block serialises accepted samples into 16-bit MCP4922 write frames and can optionally pulse LDAC so both outputs update together. It sits between the control/DSP datapath and the DAC pins.

## Interface
- `prescaler_sclk`, 10: the SPI half-period is `prescaler_sclk`+1 aclk cycles (P).
- `prescaler_sclk_width`, 4: width of the prescaler counter.
- `buffered`, 0: value of the BUF bit in every frame.
- `gain_1x`, 1: value of the GA_n bit (1 → 1x gain, 0 → 2x gain).
- `sync_update`, 1: 1 → LDAC pulse after both channels are written; 0 → `spi_ldac_n` tied low (update on CS rise).

Ports:
- `aclk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `s_axis_cha_tdata`  in  16  channel A sample; bits [11:0] used, [15:12] ignored.
- `s_axis_cha_tvalid`  in  1  channel A valid.
- `s_axis_cha_tready`  out  1  channel A ready.
- `s_axis_chb_tdata`  in  16  channel B sample; bits [11:0] used, [15:12] ignored.
- `s_axis_chb_tvalid`  in  1  channel B valid.
- `s_axis_chb_tready`  out  1  channel B ready.
- `spi_mosi`  out  1  serial data, MSB first.
- `spi_sclk`  out  1  SPI clock, mode 0, idle low.
- `spi_ss`  out  1  chip select, active low.
- `spi_ldac_n`  out  1  DAC latch strobe, active low.

## Operation
- Holding registers:
  - Each channel has a data register plus a pending flag.
  - `tready` = !pending && !reset.
  - A sample is accepted when `tvalid` && `tready`; acceptance sets pending.
- Frame layout: {ch (0=A, 1=B), `buffered`, `gain_1x`, SHDN_n=1, data[11:0]}.
- Prescaler:
  - Held at 0 in IDLE.
  - In every other state it counts 0..`prescaler_sclk`; tick = (count == `prescaler_sclk`).
  - Every non-IDLE state therefore lasts exactly P cycles.
- FSM states: IDLE, LOW, HIGH, HOLD, GAP, LDAC.
- IDLE:
  - Acts when at least one channel is pending.
  - If both are pending, it serves the channel not served last (round-robin). `last_ch` resets to B, so A goes first.
  - Loads the 16-bit shift register from the selected channel and clears that channel's pending flag in the same cycle.
  - Drives `spi_ss`=0 and sets bit_cnt=15, then moves to LOW.
- LOW: `spi_sclk`=0; on tick → `spi_sclk`=1, go to HIGH.
- HIGH:
  - On tick, `spi_sclk`=0.
  - If bit_cnt==0, go to HOLD.
  - Otherwise shift left, decrement bit_cnt, and go to LOW.
- MOSI: `spi_mosi` = shift[15]. It changes only on falling SCLK edges; the DAC samples on rising edges.
- HOLD:
  - On tick, `spi_ss`=1.
  - Sets the written flag of the served channel.
  - Goes to GAP.
- GAP (keeps CS high for at least P cycles): on tick, if `sync_update` and both written flags are set, drive `spi_ldac_n`=0, clear both flags, and go to LDAC. Otherwise go to IDLE.
- LDAC: on tick → `spi_ldac_n`=1, go to IDLE.
- Accepting a new sample for a channel during its own transfer is legal; the sample is sent in a later frame.

## Timing
- Reset values:
  - `spi_sclk`=0, `spi_ss`=1, `spi_mosi`=0.
  - `spi_ldac_n`=1 if `sync_update`, else 0.
  - Both `tready`=0 while reset is high, then 1 on the first cycle after reset.
  - Pending and written flags cleared; FSM in IDLE.
- Reset mid-frame aborts immediately: CS high, SCLK low, the sample in flight is dropped, no LDAC.
- Latency from acceptance (pending set) to `spi_ss` falling is 1 cycle, if IDLE.
- CS-low window is 33·P cycles (16 SCLK periods plus the HOLD half-period).
- Frame period:
  - Back-to-back: 1 + 34·P cycles.
  - When LDAC fires: add P.
- `tready` of the served channel rises the cycle after its IDLE load.
- A handshake in the same cycle that IDLE samples the pending flags is not visible to IDLE until the next cycle.

## Structure
- Package/header `mcp4922_pkg`: FSM state encodings and frame bit positions (CH=15, BUF=14, GA_n=13, SHDN_n=12).
- Sub-module `axis_hold_reg`, instantiated once per channel: AXI-Stream sink, data register, pending flag, clear input.

## Test plan
- Reset, then A=0x0ABC: `spi_ss` low for 33·P cycles; the 16 bits sampled at rising SCLK edges are 0x3ABC; no LDAC pulse yet (`sync_update`=1).
- Then B=0x0123: frame 0xB123; after GAP, `spi_ldac_n` low for exactly P cycles.
- A and B valid in the same cycle after reset: A is sent first, then B, frames back-to-back with a 1 + 34·P period.
- `tdata`=0xFABC on A: upper nibble ignored, frame 0x3ABC.
- `sync_update`=0: `spi_ldac_n` constantly 0; with `gain_1x`=0 and `buffered`=1, an A=0x0FFF sample gives frame 0x5FFF.
- Reset asserted at bit 8 of a frame: the next cycle shows `spi_ss`=1 and `spi_sclk`=0, pending cleared, and no LDAC pulse.
